// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Input conditioner for the board push-buttons. Each of the N_BUTTONS raw
// active-low pins is synchronised into the clk domain. A new level is accepted
// only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
// Per channel the block produces:
//   - a clean debounced level (still active-low)
//   - one-cycle press/release strobes, aligned with the level change
//   - a long-press flag, raised once the press has lasted HOLD_CYCLES cycles
//
// The debounced levels may feed the LED sequencer button inputs directly.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_raw_n  in   [N_BUTTONS] raw pins, 0 = pressed, asynchronous to clk
//   btn_n_o    out  [N_BUTTONS] debounced level, 0 = pressed
//   press_o    out  [N_BUTTONS] one-cycle strobe on debounced 1->0
//   release_o  out  [N_BUTTONS] one-cycle strobe on debounced 0->1
//   held_o     out  [N_BUTTONS] high while the debounced press has lasted
//                               at least HOLD_CYCLES cycles
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int HOLD_CYCLES     = 27_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BUTTONS-1:0] btn_raw_n,
    output logic [N_BUTTONS-1:0] btn_n_o,
    output logic [N_BUTTONS-1:0] press_o,
    output logic [N_BUTTONS-1:0] release_o,
    output logic [N_BUTTONS-1:0] held_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HD_W = $clog2(HOLD_CYCLES + 1);

    // Last count value before a differing level is accepted.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [HD_W-1:0] HD_MAX  = HD_W'(HOLD_CYCLES);
    localparam logic [HD_W-1:0] HD_ONE  = HD_W'(1);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan

        // Two-flop synchroniser. Both flops reset to "released".
        logic sync1_q;
        logic sync2_q;

        // Debounce state.
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        logic            level_q;
        logic            level_d;

        // Registered strobes.
        logic press_q;
        logic press_d;
        logic release_q;
        logic release_d;

        // Long-press state.
        logic [HD_W-1:0] hold_cnt_q;
        logic [HD_W-1:0] hold_cnt_d;
        logic            held_q;
        logic            held_d;

        // -------------------------------------------------------------------
        // Synchroniser
        // -------------------------------------------------------------------
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= btn_raw_n[i];
                sync2_q <= sync1_q;
            end
        end

        // -------------------------------------------------------------------
        // Debounce.
        // The counter only runs while the synchronised input disagrees with
        // the accepted level. Any sample that agrees, even a single-cycle
        // glitch, restarts the count from zero.
        // -------------------------------------------------------------------
        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            if (sync2_q == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_d  = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end

        // -------------------------------------------------------------------
        // Strobes.
        // They are derived from the next level, so the strobe register and
        // the level register change on the same edge. The two strobes are
        // mutually exclusive by construction.
        // -------------------------------------------------------------------
        always_comb begin
            press_d   = level_q & ~level_d;
            release_d = ~level_q & level_d;
        end

        // -------------------------------------------------------------------
        // Long press.
        // The counter is cleared while the accepted level is released, and
        // counts (saturating) while it is pressed. It is still 0 on the press
        // edge itself, so it reaches HOLD_CYCLES exactly HOLD_CYCLES edges
        // after the press strobe.
        // held is computed from the next level so that it drops on the same
        // edge that the release strobe fires.
        // -------------------------------------------------------------------
        always_comb begin
            hold_cnt_d = hold_cnt_q;
            if (level_q) begin
                hold_cnt_d = '0;
            end else if (hold_cnt_q != HD_MAX) begin
                hold_cnt_d = hold_cnt_q + HD_ONE;
            end
            held_d = ~level_d & (hold_cnt_d == HD_MAX);
        end

        // -------------------------------------------------------------------
        // State registers
        // -------------------------------------------------------------------
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt_q   <= '0;
                level_q    <= 1'b1;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                hold_cnt_q <= '0;
                held_q     <= 1'b0;
            end else begin
                db_cnt_q   <= db_cnt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
                hold_cnt_q <= hold_cnt_d;
                held_q     <= held_d;
            end
        end

        assign btn_n_o[i]   = level_q;
        assign press_o[i]   = press_q;
        assign release_o[i] = release_q;
        assign held_o[i]    = held_q;

    end : g_chan

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
//
// Self-checking bench for button_debounce with DEBOUNCE_CYCLES=4 and
// HOLD_CYCLES=10.
//
// The reference model works from observable behaviour:
//   - It keeps a history of the samples the debouncer sees, each one being
//     the raw pin two edges late.
//   - The accepted level flips when the last DEBOUNCE_CYCLES samples all
//     disagree with it.
//   - held is true once the current press has lasted HOLD_CYCLES edges.
// ---------------------------------------------------------------------------
module tb_button_debounce;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int HD = 10;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [N-1:0] btn_raw_n = '1;
    logic [N-1:0] btn_n_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic [N-1:0] held_o;

    button_debounce #(
        .N_BUTTONS      (N),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw_n(btn_raw_n),
        .btn_n_o  (btn_n_o),
        .press_o  (press_o),
        .release_o(release_o),
        .held_o   (held_o)
    );

    // -----------------------------------------------------------------------
    // Clock
    // -----------------------------------------------------------------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    logic [1:0]   raw_hist [N];   // raw value at the previous two edges
    logic [63:0]  s_hist   [N];   // samples seen by the debouncer, newest in bit 0
    int           s_len    [N];
    int           press_edge [N];
    int           edge_no;
    logic [N-1:0] exp_lvl;
    logic [N-1:0] exp_press;
    logic [N-1:0] exp_rel;
    logic [N-1:0] exp_held;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            raw_hist[i]   = 2'b11;
            s_hist[i]     = '0;
            s_len[i]      = 0;
            press_edge[i] = 0;
        end
        edge_no   = 0;
        exp_lvl   = '1;
        exp_press = '0;
        exp_rel   = '0;
        exp_held  = '0;
    endtask

    task automatic model_edge();
        logic s;
        logic old;
        if (!rst_n) return;
        edge_no++;
        for (int i = 0; i < N; i++) begin
            s = raw_hist[i][1];
            raw_hist[i] = {raw_hist[i][0], btn_raw_n[i]};
            s_hist[i] = {s_hist[i][62:0], s};
            if (s_len[i] < 64) s_len[i]++;
            old = exp_lvl[i];
            if (s_len[i] >= DB && s_hist[i][DB-1:0] == {DB{~old}}) exp_lvl[i] = ~old;
            exp_press[i] = old & ~exp_lvl[i];
            exp_rel[i]   = ~old & exp_lvl[i];
            if (exp_press[i]) press_edge[i] = edge_no;
            exp_held[i] = ~exp_lvl[i] & ((edge_no - press_edge[i]) >= HD);
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver: one clock cycle.
    // Inputs are applied at the negedge and the model advances on the
    // posedge. The task returns at the next negedge, where outputs are
    // sampled.
    // -----------------------------------------------------------------------
    task automatic tick(input logic [N-1:0] raw);
        btn_raw_n = raw;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    task automatic test_reset();
        int found;
        found = -1;
        rst_n = 1'b0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            tick(2'b00);
            checks++;
            if ({btn_n_o, press_o, release_o, held_o} !== 8'b11_00_00_00) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got %b want %b", n,
                         {btn_n_o, press_o, release_o, held_o}, 8'b11_00_00_00);
            end
        end
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick(2'b00);
            checks++;
            if ({btn_n_o, press_o, release_o, held_o} !== {exp_lvl, exp_press, exp_rel, exp_held}) begin
                errors++;
                $display("FAIL reset_exit cyc%0d: got %b want %b", n,
                         {btn_n_o, press_o, release_o, held_o}, {exp_lvl, exp_press, exp_rel, exp_held});
            end
            if (found < 0 && press_o == 2'b11) found = n;
        end
        checks++;
        if (found != DB + 1) begin
            errors++;
            $display("FAIL reset_press_latency: got %0d want %0d", found, DB + 1);
        end
        for (int n = 0; n < 10; n++) begin
            tick(2'b11);
            checks++;
            if ({btn_n_o, press_o, release_o, held_o} !== {exp_lvl, exp_press, exp_rel, exp_held}) begin
                errors++;
                $display("FAIL reset_release cyc%0d: got %b want %b", n,
                         {btn_n_o, press_o, release_o, held_o}, {exp_lvl, exp_press, exp_rel, exp_held});
            end
        end
    endtask

    task automatic test_clean_press();
        int p_idx;
        int r_idx;
        int p_cnt;
        int r_cnt;
        int ch1_moved;
        p_idx = -1; r_idx = -1; p_cnt = 0; r_cnt = 0; ch1_moved = 0;
        for (int n = 0; n < 32; n++) begin
            tick(n < 20 ? 2'b10 : 2'b11);
            checks++;
            if ({btn_n_o, press_o, release_o, held_o} !== {exp_lvl, exp_press, exp_rel, exp_held}) begin
                errors++;
                $display("FAIL clean cyc%0d: got %b want %b", n,
                         {btn_n_o, press_o, release_o, held_o}, {exp_lvl, exp_press, exp_rel, exp_held});
            end
            if (press_o[0]) begin p_cnt++; if (p_idx < 0) p_idx = n; end
            if (release_o[0]) begin r_cnt++; if (r_idx < 0) r_idx = n - 20; end
            if ({btn_n_o[1], press_o[1], release_o[1], held_o[1]} != 4'b1000) ch1_moved++;
        end
        checks++;
        if (p_idx != DB + 1) begin errors++; $display("FAIL clean_press_edge: got %0d want %0d", p_idx, DB + 1); end
        checks++;
        if (r_idx != DB + 1) begin errors++; $display("FAIL clean_release_edge: got %0d want %0d", r_idx, DB + 1); end
        checks++;
        if (p_cnt != 1 || r_cnt != 1) begin
            errors++;
            $display("FAIL clean_pulse_count: got press=%0d release=%0d want 1/1", p_cnt, r_cnt);
        end
        checks++;
        if (ch1_moved != 0) begin errors++; $display("FAIL clean_ch1_quiet: got %0d changes want 0", ch1_moved); end
    endtask

    task automatic test_bounce();
        int during;
        int p_idx;
        int p_cnt;
        during = 0; p_idx = -1; p_cnt = 0;
        // 32 cycles of 2-cycle runs (ending high), then a steady low.
        for (int n = 0; n < 44; n++) begin
            logic r0;
            r0 = (n < 32) ? logic'((n / 2) % 2) : 1'b0;
            tick({1'b1, r0});
            checks++;
            if ({btn_n_o, press_o, release_o, held_o} !== {exp_lvl, exp_press, exp_rel, exp_held}) begin
                errors++;
                $display("FAIL bounce cyc%0d: got %b want %b", n,
                         {btn_n_o, press_o, release_o, held_o}, {exp_lvl, exp_press, exp_rel, exp_held});
            end
            if (n < 32 && (btn_n_o[0] !== 1'b1 || press_o[0] || release_o[0])) during++;
            if (press_o[0]) begin p_cnt++; if (p_idx < 0) p_idx = n - 32; end
        end
        checks++;
        if (during != 0) begin errors++; $display("FAIL bounce_quiet: got %0d changes want 0", during); end
        checks++;
        if (p_cnt != 1 || p_idx != DB + 1) begin
            errors++;
            $display("FAIL bounce_settle: got count=%0d edge=%0d want 1/%0d", p_cnt, p_idx, DB + 1);
        end
        for (int n = 0; n < 10; n++) tick(2'b11);
    endtask

    task automatic test_glitch();
        int moved;
        moved = 0;
        for (int n = 0; n < 14; n++) begin
            tick((n < DB - 1) ? 2'b01 : (n == 6 ? 2'b01 : 2'b11));
            checks++;
            if ({btn_n_o, press_o, release_o, held_o} !== {exp_lvl, exp_press, exp_rel, exp_held}) begin
                errors++;
                $display("FAIL glitch cyc%0d: got %b want %b", n,
                         {btn_n_o, press_o, release_o, held_o}, {exp_lvl, exp_press, exp_rel, exp_held});
            end
            if (btn_n_o[1] !== 1'b1 || press_o[1] || release_o[1]) moved++;
        end
        checks++;
        if (moved != 0) begin errors++; $display("FAIL glitch_ch1: got %0d changes want 0", moved); end
    endtask

    task automatic test_long_press();
        int p_idx;
        int h_idx;
        int rel_ok;
        int held_seen;
        int short_press;
        logic prev_held;
        p_idx = -1; h_idx = -1; rel_ok = 0; held_seen = 0; short_press = 0;
        prev_held = 1'b0;
        for (int n = 0; n < 36; n++) begin
            tick(n < 25 ? 2'b10 : 2'b11);
            checks++;
            if ({btn_n_o, press_o, release_o, held_o} !== {exp_lvl, exp_press, exp_rel, exp_held}) begin
                errors++;
                $display("FAIL long cyc%0d: got %b want %b", n,
                         {btn_n_o, press_o, release_o, held_o}, {exp_lvl, exp_press, exp_rel, exp_held});
            end
            if (press_o[0] && p_idx < 0) p_idx = n;
            if (held_o[0] && h_idx < 0) h_idx = n;
            if (release_o[0] && !held_o[0] && prev_held) rel_ok++;
            prev_held = held_o[0];
        end
        checks++;
        if (h_idx - p_idx != HD) begin
            errors++;
            $display("FAIL long_held_delay: got %0d want %0d", h_idx - p_idx, HD);
        end
        checks++;
        if (rel_ok != 1) begin errors++; $display("FAIL long_held_drop: got %0d want 1", rel_ok); end
        // A press that lasts 9 debounced cycles must never raise held.
        for (int n = 0; n < 20; n++) begin
            tick(n < HD - 1 ? 2'b10 : 2'b11);
            checks++;
            if ({btn_n_o, press_o, release_o, held_o} !== {exp_lvl, exp_press, exp_rel, exp_held}) begin
                errors++;
                $display("FAIL short cyc%0d: got %b want %b", n,
                         {btn_n_o, press_o, release_o, held_o}, {exp_lvl, exp_press, exp_rel, exp_held});
            end
            if (held_o[0]) held_seen++;
            if (press_o[0]) short_press++;
        end
        checks++;
        if (held_seen != 0 || short_press != 1) begin
            errors++;
            $display("FAIL short_no_held: got held=%0d press=%0d want 0/1", held_seen, short_press);
        end
    endtask

    task automatic test_mid_reset();
        int found;
        found = -1;
        for (int n = 0; n < 20; n++) tick(2'b10);
        checks++;
        if ({btn_n_o[0], held_o[0]} !== {exp_lvl[0], exp_held[0]} || exp_held[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got lvl=%b held=%b want 0/1", btn_n_o[0], held_o[0]);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({btn_n_o, press_o, release_o, held_o} !== 8'b11_00_00_00) begin
            errors++;
            $display("FAIL midrst_async: got %b want %b", {btn_n_o, press_o, release_o, held_o}, 8'b11_00_00_00);
        end
        for (int n = 0; n < 2; n++) begin
            tick(2'b10);
            checks++;
            if ({btn_n_o, press_o, release_o, held_o} !== 8'b11_00_00_00) begin
                errors++;
                $display("FAIL midrst_hold cyc%0d: got %b want %b", n,
                         {btn_n_o, press_o, release_o, held_o}, 8'b11_00_00_00);
            end
        end
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick(2'b10);
            checks++;
            if ({btn_n_o, press_o, release_o, held_o} !== {exp_lvl, exp_press, exp_rel, exp_held}) begin
                errors++;
                $display("FAIL midrst_exit cyc%0d: got %b want %b", n,
                         {btn_n_o, press_o, release_o, held_o}, {exp_lvl, exp_press, exp_rel, exp_held});
            end
            if (press_o[0] && found < 0) found = n;
        end
        checks++;
        if (found != DB + 1) begin errors++; $display("FAIL midrst_repress: got %0d want %0d", found, DB + 1); end
        for (int n = 0; n < 10; n++) tick(2'b11);
    endtask

    task automatic test_random();
        int n;
        n = 0;
        while (n < 600) begin
            logic [N-1:0] raw;
            int len;
            raw = N'($urandom_range(0, 3));
            len = $urandom_range(1, 2 * DB + 2);
            for (int k = 0; k < len; k++) begin
                tick(raw);
                checks++;
                if ({btn_n_o, press_o, release_o, held_o} !== {exp_lvl, exp_press, exp_rel, exp_held}) begin
                    errors++;
                    $display("FAIL random cyc%0d: got %b want %b", n,
                             {btn_n_o, press_o, release_o, held_o}, {exp_lvl, exp_press, exp_rel, exp_held});
                end
                n++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Sequence and report
    // -----------------------------------------------------------------------
    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_press();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule : tb_button_debounce
